// File: rtl/program_dumper.sv
// Streams WORD_COUNT imem words MSB-first over a byte UART after a host request byte.
// Each byte goes out only when tx_ready is high, and the cycle after any transferred byte is left idle.
module program_dumper #(
    parameter logic [7:0]  REQUEST_CODE     = 8'hF5,
    parameter logic [7:0]  REQUEST_ACK_CODE = 8'hF6,
    parameter logic [7:0]  COMPLETION_CODE  = 8'hF2,
    parameter logic [7:0]  ERROR_CODE       = 8'hF4,
    parameter int unsigned WORD_COUNT       = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_ready,
    output logic        rd_imem,
    output logic [31:0] addr_imem,
    input  logic [31:0] data_imem,
    output logic [3:0]  state
);

    localparam logic [3:0] S_WAIT_REQ = 4'd0;
    localparam logic [3:0] S_ACK      = 4'd1;
    localparam logic [3:0] S_FETCH    = 4'd2;
    localparam logic [3:0] S_WAIT_DAT = 4'd3;
    localparam logic [3:0] S_SEND     = 4'd4;
    localparam logic [3:0] S_WAIT_TX  = 4'd5;
    localparam logic [3:0] S_COMP     = 4'd6;
    localparam logic [3:0] S_FINISHED = 4'd7;
    localparam logic [3:0] S_SEND_ERR = 4'd8;
    localparam logic [3:0] S_ERROR    = 4'd9;

    localparam logic [29:0] LAST_IDX = 30'(WORD_COUNT - 1);

    logic [3:0]  state_q, state_d;
    logic [29:0] index_q, index_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic        sent_q, sent_d;
    logic        tx_state;
    logic        dumping;

    assign tx_state = (state_q == S_ACK) || (state_q == S_SEND) ||
                      (state_q == S_COMP) || (state_q == S_SEND_ERR);
    assign dumping  = (state_q >= S_ACK) && (state_q <= S_WAIT_TX);

    // sent_q enforces the idle cycle after a transfer; reset suppresses any transfer on its own edge.
    assign tx_start  = tx_state && tx_ready && !sent_q && !reset;
    assign rd_imem   = (state_q == S_FETCH) && !reset;
    assign addr_imem = {index_q, 2'b00};
    assign state     = state_q;

    always_comb begin
        tx_data = 8'hFF;
        case (state_q)
            S_ACK:      tx_data = REQUEST_ACK_CODE;
            S_SEND:     tx_data = buf_q[31:24];
            S_COMP:     tx_data = COMPLETION_CODE;
            S_SEND_ERR: tx_data = ERROR_CODE;
            default:    tx_data = 8'hFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        sent_d  = tx_start;
        if (!enable) begin
            state_d = S_WAIT_REQ;
        end else begin
            case (state_q)
                S_WAIT_REQ: begin
                    if (rx_valid) begin
                        state_d = (rx_data == REQUEST_CODE) ? S_ACK : S_SEND_ERR;
                    end
                end
                S_ACK: begin
                    if (tx_start) begin
                        state_d = S_FETCH;
                        index_d = '0;
                    end
                end
                S_FETCH:    state_d = S_WAIT_DAT;
                S_WAIT_DAT: begin
                    buf_d   = data_imem;
                    cnt_d   = 2'd0;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (tx_start) begin
                        buf_d = {buf_q[23:0], 8'h00};
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (index_q == LAST_IDX) begin
                                state_d = S_COMP;
                            end else begin
                                index_d = index_q + 30'd1;
                                state_d = S_FETCH;
                            end
                        end else begin
                            state_d = S_WAIT_TX;
                        end
                    end
                end
                S_WAIT_TX:  state_d = S_SEND;
                S_COMP:     if (tx_start) state_d = S_FINISHED;
                S_SEND_ERR: if (tx_start) state_d = S_ERROR;
                S_FINISHED: state_d = S_FINISHED;
                S_ERROR:    state_d = S_ERROR;
                default:    state_d = S_WAIT_REQ;
            endcase
            // A host error byte aborts any active dump phase.
            if (dumping && rx_valid && (rx_data == ERROR_CODE)) begin
                state_d = S_SEND_ERR;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_WAIT_REQ;
            index_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            sent_q  <= sent_d;
        end
    end

endmodule

// File: tb/tb_program_dumper.sv
// Directed bench for program_dumper with a UART transmitter model and a two-word imem.
module tb_program_dumper;

    localparam logic [3:0] S_WAIT_REQ = 4'd0;
    localparam logic [3:0] S_SEND     = 4'd4;
    localparam logic [3:0] S_WAIT_TX  = 4'd5;
    localparam logic [3:0] S_FINISHED = 4'd7;
    localparam logic [3:0] S_ERROR    = 4'd9;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready = 1'b1;
    logic        rd_imem;
    logic [31:0] addr_imem;
    logic [31:0] data_imem = 32'hA5A5A5A5;
    logic [3:0]  state;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0]  tx_q[$];
    int          tx_t[$];
    logic [31:0] rd_q[$];
    logic [7:0]  exp_bytes[10] = '{8'hF6, 8'h12, 8'h34, 8'h56, 8'h78,
                                   8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hF2};

    int          cyc = 0;
    int          busy = 0;
    int          hold = 0;
    bit          hold_en = 1'b0;
    int          ready_viol = 0;
    int          gap_viol = 0;
    logic        xfer_s = 1'b0;
    logic        prev_xfer = 1'b0;
    logic [7:0]  byte_s = 8'h00;
    logic        rd_s = 1'b0;
    logic [31:0] addr_s = 32'h0;

    program_dumper #(.WORD_COUNT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .rd_imem   (rd_imem),
        .addr_imem (addr_imem),
        .data_imem (data_imem),
        .state     (state)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h12345678;
            32'd4:   return 32'hDEADBEEF;
            default: return 32'h00000000;
        endcase
    endfunction

    // Sample handshake and read strobe mid-cycle; the inputs do not change again before the next edge.
    always @(negedge clock) begin
        xfer_s = tx_start && tx_ready;
        byte_s = tx_data;
        rd_s   = rd_imem;
        addr_s = addr_imem;
        if (tx_start && !tx_ready) ready_viol++;
        if (tx_start && prev_xfer) gap_viol++;
        prev_xfer = xfer_s;
    end

    always @(posedge clock) begin
        cyc++;
        #1;
        if (xfer_s) begin
            tx_q.push_back(byte_s);
            tx_t.push_back(cyc);
            busy = 2;
            if (hold_en && byte_s == 8'h34) hold = 20;
        end else begin
            if (busy > 0) busy--;
            if (hold > 0) hold--;
        end
        if (rd_s) begin
            rd_q.push_back(addr_s);
            data_imem = mem_word(addr_s);
        end else begin
            data_imem = 32'hA5A5A5A5;
        end
        tx_ready = (busy == 0) && (hold == 0);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_state(input logic [3:0] s, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (state === s) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        rx_valid = 1'b0;
        step(2);
        reset = 1'b0;
        hold_en = 1'b0;
        step(4);
        tx_q.delete();
        tx_t.delete();
        rd_q.delete();
    endtask

    task automatic test_reset();
        step(2);
        total_cnt++; if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state); else pass_cnt++;
        total_cnt++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b want 0", tx_start); else pass_cnt++;
        total_cnt++; if (rd_imem !== 1'b0) $display("FAIL reset_rd_imem got %b want 0", rd_imem); else pass_cnt++;
        total_cnt++; if (addr_imem !== 32'h0) $display("FAIL reset_addr got %h want 0", addr_imem); else pass_cnt++;
        total_cnt++; if (tx_data !== 8'hFF) $display("FAIL reset_tx_data got %h want ff", tx_data); else pass_cnt++;
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_dump();
        bit ok;
        logic [7:0] got;
        int n;
        do_reset();
        send_rx(8'hF5);
        wait_state(S_FINISHED, 400, ok);
        total_cnt++; if (!ok) $display("FAIL dump_reach_finished got state %0d want 7", state); else pass_cnt++;
        step(3);
        total_cnt++; if (tx_q.size() != 10) $display("FAIL dump_byte_count got %0d want 10", tx_q.size()); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            total_cnt++; if (got !== exp_bytes[i]) $display("FAIL dump_byte%0d got %h want %h", i, got, exp_bytes[i]); else pass_cnt++;
        end
        total_cnt++; if (rd_q.size() != 2) $display("FAIL dump_read_count got %0d want 2", rd_q.size()); else pass_cnt++;
        total_cnt++; if (rd_q.size() < 1 || rd_q[0] !== 32'd0) $display("FAIL dump_read0_addr got %0d reads want addr 0", rd_q.size()); else pass_cnt++;
        total_cnt++; if (rd_q.size() < 2 || rd_q[1] !== 32'd4) $display("FAIL dump_read1_addr got %0d reads want addr 4", rd_q.size()); else pass_cnt++;
        n = tx_q.size();
        send_rx(8'hF5);
        step(8);
        total_cnt++; if (state !== S_FINISHED) $display("FAIL finished_hold got %0d want 7", state); else pass_cnt++;
        total_cnt++; if (tx_q.size() != n) $display("FAIL finished_quiet got %0d bytes want %0d", tx_q.size(), n); else pass_cnt++;
    endtask

    task automatic test_error_request();
        bit ok;
        do_reset();
        send_rx(8'h00);
        wait_state(S_ERROR, 50, ok);
        total_cnt++; if (!ok) $display("FAIL badreq_reach_error got state %0d want 9", state); else pass_cnt++;
        step(3);
        send_rx(8'hF5);
        step(6);
        total_cnt++; if (state !== S_ERROR) $display("FAIL badreq_error_hold got %0d want 9", state); else pass_cnt++;
        total_cnt++; if (tx_q.size() != 1) $display("FAIL badreq_byte_count got %0d want 1", tx_q.size()); else pass_cnt++;
        total_cnt++; if (tx_q.size() < 1 || tx_q[0] !== 8'hF4) $display("FAIL badreq_byte got %0d bytes want f4", tx_q.size()); else pass_cnt++;
        enable = 1'b0;
        step(1);
        total_cnt++; if (state !== S_WAIT_REQ) $display("FAIL badreq_enable_low got %0d want 0", state); else pass_cnt++;
        enable = 1'b1;
        step(1);
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] got;
        do_reset();
        hold_en = 1'b1;
        send_rx(8'hF5);
        wait_state(S_FINISHED, 600, ok);
        total_cnt++; if (!ok) $display("FAIL bp_reach_finished got state %0d want 7", state); else pass_cnt++;
        step(3);
        total_cnt++; if (tx_q.size() != 10) $display("FAIL bp_byte_count got %0d want 10", tx_q.size()); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            total_cnt++; if (got !== exp_bytes[i]) $display("FAIL bp_byte%0d got %h want %h", i, got, exp_bytes[i]); else pass_cnt++;
        end
        total_cnt++;
        if (tx_t.size() < 4 || (tx_t[3] - tx_t[2]) < 21) $display("FAIL bp_stall_gap got %0d bytes want 0x56 at least 21 cycles after 0x34", tx_t.size());
        else pass_cnt++;
        hold_en = 1'b0;
    endtask

    task automatic test_rx_error_abort();
        bit ok;
        do_reset();
        send_rx(8'hF5);
        wait_state(S_WAIT_TX, 100, ok);
        total_cnt++; if (!ok) $display("FAIL rxerr_reach_wait_tx got state %0d want 5", state); else pass_cnt++;
        send_rx(8'hF4);
        wait_state(S_ERROR, 100, ok);
        total_cnt++; if (!ok) $display("FAIL rxerr_reach_error got state %0d want 9", state); else pass_cnt++;
        step(10);
        total_cnt++; if (tx_q.size() != 3) $display("FAIL rxerr_byte_count got %0d want 3", tx_q.size()); else pass_cnt++;
        total_cnt++; if (tx_q.size() < 3 || tx_q[1] !== 8'h12 || tx_q[2] !== 8'hF4) $display("FAIL rxerr_bytes got %0d bytes want f6,12,f4", tx_q.size()); else pass_cnt++;
        total_cnt++; if (state !== S_ERROR) $display("FAIL rxerr_state got %0d want 9", state); else pass_cnt++;
    endtask

    task automatic test_enable_abort();
        bit ok;
        logic [7:0] got;
        do_reset();
        send_rx(8'hF5);
        for (int i = 0; i < 200 && tx_q.size() < 7; i++) step(1);
        total_cnt++; if (tx_q.size() < 7) $display("FAIL abort_reach_word1 got %0d bytes want 7", tx_q.size()); else pass_cnt++;
        enable = 1'b0;
        step(1);
        total_cnt++; if (state !== S_WAIT_REQ) $display("FAIL abort_state got %0d want 0", state); else pass_cnt++;
        total_cnt++; if (tx_start !== 1'b0 || rd_imem !== 1'b0) $display("FAIL abort_strobes got tx_start %b rd_imem %b want 0 0", tx_start, rd_imem); else pass_cnt++;
        step(4);
        tx_q.delete();
        tx_t.delete();
        rd_q.delete();
        enable = 1'b1;
        step(1);
        send_rx(8'hF5);
        wait_state(S_FINISHED, 400, ok);
        total_cnt++; if (!ok) $display("FAIL redump_reach_finished got state %0d want 7", state); else pass_cnt++;
        step(3);
        for (int i = 0; i < 10; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            total_cnt++; if (got !== exp_bytes[i]) $display("FAIL redump_byte%0d got %h want %h", i, got, exp_bytes[i]); else pass_cnt++;
        end
        total_cnt++; if (rd_q.size() != 2 || rd_q[0] !== 32'd0 || rd_q[1] !== 32'd4) $display("FAIL redump_reads got %0d reads want addrs 0,4", rd_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        int nb;
        int nr;
        do_reset();
        send_rx(8'hF5);
        for (int i = 0; i < 200 && tx_q.size() < 5; i++) step(1);
        wait_state(S_SEND, 100, ok);
        total_cnt++; if (!ok || addr_imem !== 32'd4) $display("FAIL rstmid_reach_word1 got state %0d addr %h want 4 and 4", state, addr_imem); else pass_cnt++;
        nb = tx_q.size();
        nr = rd_q.size();
        reset = 1'b1;
        step(1);
        total_cnt++; if (state !== S_WAIT_REQ) $display("FAIL rstmid_state got %0d want 0", state); else pass_cnt++;
        total_cnt++; if (tx_start !== 1'b0) $display("FAIL rstmid_tx_start got %b want 0", tx_start); else pass_cnt++;
        total_cnt++; if (addr_imem !== 32'h0) $display("FAIL rstmid_addr got %h want 0", addr_imem); else pass_cnt++;
        reset = 1'b0;
        step(10);
        total_cnt++; if (tx_q.size() != nb) $display("FAIL rstmid_no_bytes got %0d want %0d", tx_q.size(), nb); else pass_cnt++;
        total_cnt++; if (rd_q.size() != nr) $display("FAIL rstmid_no_reads got %0d want %0d", rd_q.size(), nr); else pass_cnt++;
    endtask

    task automatic test_flow_rules();
        total_cnt++; if (ready_viol != 0) $display("FAIL tx_start_without_ready got %0d want 0", ready_viol); else pass_cnt++;
        total_cnt++; if (gap_viol != 0) $display("FAIL tx_start_after_transfer got %0d want 0", gap_viol); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_dump();
        test_error_request();
        test_backpressure();
        test_rx_error_abort();
        test_enable_abort();
        test_reset_mid_dump();
        test_flow_rules();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
